// File: rtl/rng_word_collector_if.sv
// Handshake bundle between the word collector (master) and the xorshift RNG (slave).
// rng_start_n requests one word; rng_random is valid while rng_ready_n is low.
interface rng_word_collector_if #(
    parameter int unsigned WORD = 32
);
    logic            rng_start_n;
    logic            rng_ready_n;
    logic [WORD-1:0] rng_random;

    modport master (
        output rng_start_n,
        input  rng_ready_n,
        input  rng_random
    );

    modport slave (
        input  rng_start_n,
        output rng_ready_n,
        output rng_random
    );
endinterface

// File: rtl/rng_word_collector.sv
// Collects WIDTH/WORD words from the RNG into one wide candidate, optionally forcing the
// MSB and LSB, and pulses done when the candidate is complete. A word that is not returned
// within TIMEOUT wait cycles aborts the candidate and raises a sticky err.
module rng_word_collector #(
    parameter int unsigned WIDTH   = 512,
    parameter int unsigned WORD    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    force_msb,
    input  logic                    force_odd,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [WIDTH-1:0]        candidate,
    rng_word_collector_if.master    rng
);

    localparam int unsigned N     = WIDTH / WORD;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(N - 1);
    localparam logic [TMR_W-1:0] TimeoutLast = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   index_q;
    logic [TMR_W-1:0]   timer_q;
    logic               msb_q;
    logic               odd_q;
    logic [WIDTH-1:0]   cand_capture;

    // Candidate as it would look after capturing the current RNG word (forcing on the last).
    always_comb begin
        cand_capture = candidate;
        for (int i = 0; i < N; i++) begin
            if (index_q == IDX_W'(i)) begin
                cand_capture[i*WORD +: WORD] = rng.rng_random;
            end
        end
        if (index_q == LastIdx) begin
            if (msb_q) cand_capture[WIDTH-1] = 1'b1;
            if (odd_q) cand_capture[0]       = 1'b1;
        end
    end

    // Request/capture FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            index_q         <= '0;
            timer_q         <= '0;
            msb_q           <= 1'b0;
            odd_q           <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            candidate       <= '0;
            rng.rng_start_n <= 1'b1;
        end else begin
            done            <= 1'b0;
            rng.rng_start_n <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        msb_q           <= force_msb;
                        odd_q           <= force_odd;
                        err             <= 1'b0;
                        index_q         <= '0;
                        busy            <= 1'b1;
                        rng.rng_start_n <= 1'b0;
                        state_q         <= StIssue;
                    end
                end
                StIssue: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (!rng.rng_ready_n) begin
                        candidate <= cand_capture;
                        if (index_q == LastIdx) begin
                            done <= 1'b1;
                            // A held req restarts in the done cycle so back-to-back
                            // candidates need no idle gap.
                            if (req) begin
                                msb_q           <= force_msb;
                                odd_q           <= force_odd;
                                index_q         <= '0;
                                rng.rng_start_n <= 1'b0;
                                state_q         <= StIssue;
                            end else begin
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end else begin
                            index_q         <= index_q + 1'b1;
                            rng.rng_start_n <= 1'b0;
                            state_q         <= StIssue;
                        end
                    end else if (timer_q == TimeoutLast) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_word_collector.sv
// Directed bench for rng_word_collector (WIDTH=64, WORD=32, TIMEOUT=8) with a small
// RNG responder driven on the falling edge.
module tb_rng_word_collector;

    logic        clk;
    logic        rst;
    logic        req;
    logic        force_msb;
    logic        force_odd;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] candidate;

    rng_word_collector_if #(.WORD(32)) rng_bus ();

    rng_word_collector #(
        .WIDTH  (64),
        .WORD   (32),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .force_msb(force_msb),
        .force_odd(force_odd),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .candidate(candidate),
        .rng      (rng_bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // RNG responder state
    logic [31:0] words[$];
    int          rng_delay  = 0;
    bit          rng_hold   = 0;
    bit          pending    = 0;
    int          cnt        = 0;
    int          starts     = 0;
    int          consec     = 0;
    bit          prev_low   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // RNG model: answers each start pulse after rng_delay wait cycles, one-cycle ready.
    initial begin
        rng_bus.rng_ready_n = 1'b1;
        rng_bus.rng_random  = '0;
        forever begin
            @(negedge clk);
            rng_bus.rng_ready_n = 1'b1;
            if (pending) begin
                if (cnt == 0) begin
                    rng_bus.rng_ready_n = 1'b0;
                    rng_bus.rng_random  = (words.size() > 0) ? words.pop_front() : 32'h0;
                    pending = 0;
                end else begin
                    cnt--;
                end
            end
            if (rng_bus.rng_start_n == 1'b0) begin
                starts++;
                if (prev_low) consec++;
                if (!rng_hold) begin
                    pending = 1;
                    cnt     = rng_delay;
                end
            end
            prev_low = (rng_bus.rng_start_n == 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic m, input logic o);
        force_msb = m;
        force_odd = o;
        req       = 1'b1;
        tick();
        req       = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    int  c;
    int  s0;
    bit  done_seen;

    initial begin
        rst = 1'b1; req = 1'b0; force_msb = 1'b0; force_odd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cand", candidate, 64'd0);
        check("rst_start_n", 64'(rng_bus.rng_start_n), 64'd1);

        // Zero-wait basic candidate
        words = '{32'h12345678, 32'h9ABCDEF0};
        rng_delay = 0;
        s0 = starts;
        run_req(1'b0, 1'b0);
        check("t1_busy_after_accept", 64'(busy), 64'd1);
        check("t1_start_low_issue", 64'(rng_bus.rng_start_n), 64'd0);
        wait_done(20, c);
        check("t1_latency", 64'(c), 64'd4);
        check("t1_busy_in_done", 64'(busy), 64'd0);
        check("t1_cand", candidate, 64'h9ABCDEF0_12345678);
        check("t1_starts", 64'(starts - s0), 64'd2);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_cand_stable", candidate, 64'h9ABCDEF0_12345678);

        // Forced bits over zero words, then all-ones without forcing
        words = '{32'h0, 32'h0};
        run_req(1'b1, 1'b1);
        wait_done(20, c);
        check("t2_latency", 64'(c), 64'd4);
        check("t2_cand_forced", candidate, 64'h80000000_00000001);
        words = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        run_req(1'b0, 1'b0);
        wait_done(20, c);
        check("t2_cand_ones", candidate, 64'hFFFFFFFF_FFFFFFFF);

        // Five wait cycles per word
        words = '{32'h2468ACE0, 32'h13579BDE};
        rng_delay = 5;
        s0 = starts;
        run_req(1'b0, 1'b0);
        wait_done(40, c);
        check("t3_latency", 64'(c), 64'd14);
        check("t3_cand", candidate, 64'h13579BDE_2468ACE0);
        check("t3_starts", 64'(starts - s0), 64'd2);
        rng_delay = 0;
        tick();

        // Timeout: RNG never answers
        rng_hold = 1;
        done_seen = 0;
        c = -1;
        run_req(1'b1, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done === 1'b1) done_seen = 1;
            if (err === 1'b1) begin
                c = i;
                break;
            end
        end
        check("t4_err_edge", 64'(c), 64'd9);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_no_done", 64'(done_seen), 64'd0);
        check("t4_cand_kept", candidate, 64'h13579BDE_2468ACE0);
        tick();
        tick();
        check("t4_err_sticky", 64'(err), 64'd1);
        rng_hold = 0;
        words = '{32'h11111111, 32'h22222222};
        run_req(1'b0, 1'b0);
        check("t4_err_cleared", 64'(err), 64'd0);
        wait_done(20, c);
        check("t4_recover_latency", 64'(c), 64'd4);
        check("t4_recover_cand", candidate, 64'h22222222_11111111);

        // req pulsed mid-operation is ignored
        words = '{32'h33333333, 32'h44444444};
        s0 = starts;
        run_req(1'b0, 1'b0);
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_done(20, c);
        check("t5_remaining", 64'(c), 64'd2);
        check("t5_cand", candidate, 64'h44444444_33333333);
        tick();
        tick();
        check("t5_not_queued", 64'(busy), 64'd0);
        check("t5_starts", 64'(starts - s0), 64'd2);

        // Reset during the second word's wait; late response ignored
        words = '{32'h55555555, 32'h66666666};
        rng_delay = 3;
        run_req(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_cand", candidate, 64'd0);
        check("t6_rst_start_n", 64'(rng_bus.rng_start_n), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check("t6_late_cand", candidate, 64'd0);
        check("t6_late_busy", 64'(busy), 64'd0);
        check("t6_late_done", 64'(done), 64'd0);
        rng_delay = 0;

        // req held: three back-to-back candidates, force bits re-latched each accept
        words = '{32'h00000000, 32'h00000000, 32'hFFFFFFFE, 32'h7FFFFFFF,
                  32'hCAFEBABE, 32'hDEADBEEF};
        s0 = starts;
        force_msb = 1'b1;
        force_odd = 1'b0;
        req = 1'b1;
        tick();
        force_msb = 1'b0;
        force_odd = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("t7_done_k%0d", k), 64'(done), 64'((k % 4) == 0));
            if (k == 4) begin
                check("t7_cand1", candidate, 64'h80000000_00000000);
                check("t7_busy1", 64'(busy), 64'd1);
                force_odd = 1'b0;
            end
            if (k == 8) begin
                check("t7_cand2", candidate, 64'h7FFFFFFF_FFFFFFFF);
                check("t7_busy2", 64'(busy), 64'd1);
                req = 1'b0;
            end
            if (k == 12) begin
                check("t7_cand3", candidate, 64'hDEADBEEF_CAFEBABE);
                check("t7_busy3", 64'(busy), 64'd0);
            end
        end
        check("t7_starts", 64'(starts - s0), 64'd6);
        check("no_consecutive_start_low", 64'(consec), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
